reg_write_demux: RTL and testbench

// - Write-side counterpart of the register-file read muxes: buffers write-back requests and decodes each into a one-hot register write enable.
// - Sits between the WB pipeline stage and the 32x64 register file.
// - Absorbs regfile stall cycles with a small FIFO and issues one write per cycle.
// - ZERO_REG is hard-wired zero, so writes to it are consumed but never enabled.

---
 rtl/reg_write_demux.sv | 106 ++++++++++
 tb/tb_reg_write_demux.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_demux.sv
// Register-file write demux: buffers write-back requests in a small FIFO and issues
// one registered one-hot write per cycle. Optional bypass search when WR_BYPASS_EN is defined.
module reg_write_demux #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5,
  parameter int DEPTH      = 2,
  parameter int ZERO_REG   = 31,
  localparam int NREG      = 2**ADDR_WIDTH,
  localparam int CW        = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr_valid,
  output logic                  wr_ready,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rf_stall,
  output logic [NREG-1:0]       rf_we,
  output logic [ADDR_WIDTH-1:0] rf_wr_addr,
  output logic [DATA_WIDTH-1:0] rf_wdata,
`ifdef WR_BYPASS_EN
  input  logic [ADDR_WIDTH-1:0] byp_addr,
  output logic                  byp_hit,
  output logic [DATA_WIDTH-1:0] byp_data,
`endif
  output logic [CW-1:0]         count
);

  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] data;
  } wr_req_t;

  wr_req_t       mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic          push, pop;
  wr_req_t       head;

  // Ready depends on occupancy only, so a full queue stays closed even on a pop cycle.
  assign wr_ready = (count < CW'(DEPTH));
  assign push     = wr_valid && wr_ready;
  assign pop      = (count != '0) && !rf_stall;
  assign head     = mem[rptr];

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{addr: wr_addr, data: wr_data};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rf_we      <= '0;
      rf_wr_addr <= '0;
      rf_wdata   <= '0;
    end else if (pop) begin
      rf_we      <= (head.addr == ADDR_WIDTH'(ZERO_REG)) ? '0 : (NREG'(1) << head.addr);
      rf_wr_addr <= head.addr;
      rf_wdata   <= head.data;
    end else begin
      rf_we      <= '0;
    end
  end

`ifdef WR_BYPASS_EN
  // Scan oldest to youngest so the tail-most match overrides everything older.
  always_comb begin
    logic [PW-1:0] idx;
    byp_hit  = 1'b0;
    byp_data = '0;
    idx      = '0;
    if (rf_we != '0 && rf_wr_addr == byp_addr) begin
      byp_hit  = 1'b1;
      byp_data = rf_wdata;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr + PW'(i);
      if (i < int'(count) && mem[idx].addr == byp_addr) begin
        byp_hit  = 1'b1;
        byp_data = mem[idx].data;
      end
    end
    if (byp_addr == ADDR_WIDTH'(ZERO_REG)) begin
      byp_hit  = 1'b0;
      byp_data = '0;
    end
  end
`endif

endmodule

// File: tb/tb_reg_write_demux.sv
// Scoreboard bench for reg_write_demux: stimulus queues expected rf_we pulses,
// a negedge monitor pops and compares every pulse the DUT issues.
module tb_reg_write_demux;

  localparam int DW = 64, AW = 5, NREG = 32, CW = 2;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            wr_valid;
  logic            wr_ready;
  logic [AW-1:0]   wr_addr;
  logic [DW-1:0]   wr_data;
  logic            rf_stall;
  logic [NREG-1:0] rf_we;
  logic [AW-1:0]   rf_wr_addr;
  logic [DW-1:0]   rf_wdata;
  logic [CW-1:0]   count;
`ifdef WR_BYPASS_EN
  logic [AW-1:0]   byp_addr;
  logic            byp_hit;
  logic [DW-1:0]   byp_data;
`endif

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  reg_write_demux dut (
    .clk(clk), .reset_n(reset_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_addr(wr_addr), .wr_data(wr_data),
    .rf_stall(rf_stall),
    .rf_we(rf_we), .rf_wr_addr(rf_wr_addr), .rf_wdata(rf_wdata),
`ifdef WR_BYPASS_EN
    .byp_addr(byp_addr), .byp_hit(byp_hit), .byp_data(byp_data),
`endif
    .count(count)
  );

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: every rf_we pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && rf_we !== '0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: got rf_we %0h expected none", rf_we);
      end else begin
        exp_t e;
        logic [NREG-1:0] one;
        e   = exp_q.pop_front();
        one = NREG'(1) << e.addr;
        chk("sb_we",   DW'(rf_we),      DW'(one));
        chk("sb_addr", DW'(rf_wr_addr), DW'(e.addr));
        chk("sb_data", rf_wdata,        e.data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one edge; expect a pulse later unless it targets the zero register.
  task automatic push(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_pulse);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    if (expect_pulse && a != AW'(31)) exp_q.push_back('{addr: a, data: d});
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
    reset_n  = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rf_stall = 1'b0;
`ifdef WR_BYPASS_EN
    byp_addr = '0;
`endif
    #12;
    chk("rst_count", DW'(count), 0);
    chk("rst_we",    DW'(rf_we), 0);
    chk("rst_ready", DW'(wr_ready), 1);
    chk("rst_wdata", rf_wdata, 0);
    reset_n = 1'b1;
    tick();

    // Latency: push at edge N, pulse visible only in cycle N+1.
    push(5, 64'hDEAD_BEEF, 1);
    chk("lat_n_we", DW'(rf_we), 0);
    chk("lat_n_count", DW'(count), 1);
    tick();
    chk("lat_n1_we", DW'(rf_we), 64'h20);
    chk("lat_n1_data", rf_wdata, 64'hDEAD_BEEF);
    chk("lat_n1_count", DW'(count), 0);
    tick();
    chk("lat_n2_we", DW'(rf_we), 0);

    // Stall fills the queue, release drains in order.
    rf_stall = 1'b1;
    push(3, 64'h33, 1);
    push(7, 64'h77, 1);
    chk("stall_count", DW'(count), 2);
    chk("stall_ready", DW'(wr_ready), 0);
    chk("stall_we", DW'(rf_we), 0);
    tick();
    chk("stall_hold_count", DW'(count), 2);
    chk("stall_hold_we", DW'(rf_we), 0);
    rf_stall = 1'b0;
    tick();
    chk("drain1_we", DW'(rf_we), 64'h8);
    chk("drain1_count", DW'(count), 1);
    tick();
    chk("drain2_we", DW'(rf_we), 64'h80);
    chk("drain2_count", DW'(count), 0);
    tick();

    // Zero-register write consumes a slot and a pop with no enable.
    push(31, 64'h1, 1);
    chk("zr_count", DW'(count), 1);
    tick();
    chk("zr_we", DW'(rf_we), 0);
    chk("zr_count_after", DW'(count), 0);
    chk("zr_ready", DW'(wr_ready), 1);

    // Back-to-back stream 0..9 exercises pointer wrap.
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_addr  = AW'(i);
      wr_data  = 64'hA000 + DW'(i);
      exp_q.push_back('{addr: AW'(i), data: 64'hA000 + DW'(i)});
      if (wr_ready !== 1'b1) chk("stream_ready", DW'(wr_ready), 1);
      tick();
    end
    wr_valid = 1'b0;
    repeat (3) tick();
    chk("stream_count", DW'(count), 0);
    chk("stream_drained", DW'(exp_q.size()), 0);

    // Reset with two queued entries: everything discarded, no pulse after release.
    rf_stall = 1'b1;
    push(9, 64'h99, 0);
    push(10, 64'hAA, 0);
    chk("prerst_count", DW'(count), 2);
    reset_n = 1'b0;
    #1;
    chk("midrst_count", DW'(count), 0);
    chk("midrst_we", DW'(rf_we), 0);
    chk("midrst_ready", DW'(wr_ready), 1);
    rf_stall = 1'b0;
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    chk("postrst_count", DW'(count), 0);

`ifdef WR_BYPASS_EN
    rf_stall = 1'b1;
    push(4, 64'hAAAA, 1);
    push(4, 64'hBBBB, 1);
    byp_addr = 4;
    #1;
    chk("byp_hit", DW'(byp_hit), 1);
    chk("byp_data", byp_data, 64'hBBBB);
    byp_addr = 31;
    #1;
    chk("byp_zr_hit", DW'(byp_hit), 0);
    chk("byp_zr_data", byp_data, 0);
    byp_addr = 6;
    #1;
    chk("byp_miss", DW'(byp_hit), 0);
    rf_stall = 1'b0;
    repeat (4) tick();
`endif

    chk("final_queue_empty", DW'(exp_q.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
